// File: rtl/zigzag_pkg.sv
// Shared types and zigzag scan tables for the zigzag scan buffer.
package zigzag_pkg;

  typedef enum logic {LOAD = 1'b0, SCAN = 1'b1} state_t;

  // Entry [pos] holds the raster index visited at scan position pos.
  localparam logic [15:0][3:0] ZZ4 = {4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
                                      4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0};

  typedef logic [63:0][5:0] zz8_t;

  // Walk the anti-diagonals r+c=s, alternating direction on each diagonal.
  function automatic zz8_t gen_zz8();
    zz8_t t;
    int   k;
    int   r;
    t = '0;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (s % 2 == 0) r = ((s < 8) ? s : 7) - i;
        else            r = ((s < 8) ? 0 : s - 7) + i;
        if (r >= 0 && r <= 7 && s - r >= 0 && s - r <= 7 && k < 64) begin
          t[k] = 6'(r * 8 + s - r);
          k++;
        end
      end
    end
    return t;
  endfunction

  localparam zz8_t ZZ8 = gen_zz8();

  function automatic int zz_index(int blk_dim, int pos);
    if (blk_dim == 8) return int'(ZZ8[pos[5:0]]);
    return int'(ZZ4[pos[3:0]]);
  endfunction

endpackage

// File: rtl/zigzag_scan_buffer_addr_gen.sv
// Scan-side read counter and zigzag address lookup.
module zigzag_addr_gen
  import zigzag_pkg::*;
#(
  parameter  int BLK_DIM = 4,
  localparam int NCOEF   = BLK_DIM * BLK_DIM,
  localparam int AW      = $clog2(NCOEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] rd_idx,
  output logic          rd_last
);

  logic [AW-1:0] rd_cnt_q, rd_cnt_d;

  // NCOEF is a power of two, so the counter wraps to 0 after the last read.
  always_comb begin
    rd_cnt_d = rd_en ? rd_cnt_q + AW'(1) : rd_cnt_q;
    rd_idx   = rd_cnt_q;
    rd_last  = (rd_cnt_q == AW'(NCOEF - 1));
    rd_addr  = AW'(zz_index(BLK_DIM, int'(rd_cnt_q)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_cnt_q <= '0;
    else        rd_cnt_q <= rd_cnt_d;
  end

endmodule

// File: rtl/zigzag_scan_buffer.sv
// Raster-in / zigzag-out coefficient block buffer with per-block non-zero count.
// Optional ZZ_PING_PONG_EN: two banks so loading and scanning overlap.
module zigzag_scan_buffer
  import zigzag_pkg::*;
#(
  parameter  int WIDTH   = 9,
  parameter  int BLK_DIM = 4,
  localparam int NCOEF   = BLK_DIM * BLK_DIM,
  localparam int AW      = $clog2(NCOEF),
  localparam int CW      = $clog2(NCOEF + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [AW-1:0]           out_idx,
  output logic                    out_last,
  output logic [CW-1:0]           out_nz_count
);

`ifdef ZZ_PING_PONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  localparam int NB = PP ? 2 : 1;
  localparam int MW = $clog2(NB * NCOEF);

  if (BLK_DIM != 4 && BLK_DIM != 8) begin : g_bad_dim
    $error("zigzag_scan_buffer: BLK_DIM must be 4 or 8");
  end

  logic signed [WIDTH-1:0] mem [NB*NCOEF];

  state_t        st_q [2], st_d [2];
  logic [CW-1:0] nz_bank_q [2], nz_bank_d [2];
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] nz_acc_q, nz_acc_d, nz_inc;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic          rd_done_q, rd_done_d, rdy_en_q;
  logic          in_fire, out_fire, advance, rd_en, scan_free;
  logic [AW-1:0] rd_addr, rd_idx;
  logic          rd_last;

  logic signed [WIDTH-1:0] rd_data_p0, out_data_p1;
  logic [AW-1:0]           idx_p0, out_idx_p1;
  logic [CW-1:0]           nz_p0, out_nz_p1;
  logic                    last_p0, out_last_p1, vld_p0, vld_p1;

  zigzag_addr_gen #(.BLK_DIM(BLK_DIM)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_idx  (rd_idx),
    .rd_last (rd_last)
  );

  // Single bank frees on the out_last transfer; ping-pong frees once the last read is issued.
  always_comb begin
    in_ready  = rdy_en_q && (st_q[wr_bank_q] == LOAD);
    in_fire   = in_valid && in_ready;
    advance   = !vld_p1 || out_ready;
    out_fire  = vld_p1 && out_ready;
    rd_en     = advance && (st_q[rd_bank_q] == SCAN) && !rd_done_q;
    scan_free = PP ? (rd_en && rd_last) : (out_fire && out_last_p1);
    nz_inc    = nz_acc_q + CW'(in_data != '0);

    st_d      = st_q;
    nz_bank_d = nz_bank_q;
    wr_cnt_d  = wr_cnt_q;
    nz_acc_d  = nz_acc_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    rd_done_d = rd_done_q;

    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
      nz_acc_d = nz_inc;
      if (wr_cnt_q == AW'(NCOEF - 1)) begin
        st_d[wr_bank_q]      = SCAN;
        nz_bank_d[wr_bank_q] = nz_inc;
        nz_acc_d             = '0;
        wr_bank_d            = wr_bank_q ^ PP;
      end
    end
    if (rd_en && rd_last) rd_done_d = 1'b1;
    if (scan_free) begin
      st_d[rd_bank_q] = LOAD;
      rd_bank_d       = rd_bank_q ^ PP;
      rd_done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= '{LOAD, LOAD};
      nz_bank_q <= '{default: '0};
      wr_cnt_q  <= '0;
      nz_acc_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_done_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      nz_bank_q <= nz_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      nz_acc_q  <= nz_acc_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_done_q <= rd_done_d;
      rdy_en_q  <= 1'b1;
    end
  end

  // Stage p0: synchronous BRAM read, held while the output register is stalled.
  always_ff @(posedge clk) begin
    if (in_fire) mem[MW'({wr_bank_q, wr_cnt_q})] <= in_data;
    if (rd_en) begin
      rd_data_p0 <= mem[MW'({rd_bank_q, rd_addr})];
      idx_p0     <= rd_idx;
      last_p0    <= rd_last;
      nz_p0      <= nz_bank_q[rd_bank_q];
    end
  end

  // Stage p1: output register, the only thing the consumer sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_idx_p1  <= '0;
      out_last_p1 <= 1'b0;
      out_nz_p1   <= '0;
    end else if (advance) begin
      vld_p0 <= rd_en;
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        out_data_p1 <= rd_data_p0;
        out_idx_p1  <= idx_p0;
        out_last_p1 <= last_p0;
        out_nz_p1   <= nz_p0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = out_data_p1;
  assign out_idx      = out_idx_p1;
  assign out_last     = out_last_p1;
  assign out_nz_count = out_nz_p1;

endmodule

// File: tb/tb_zigzag_scan_buffer.sv
// Directed testbench for zigzag_scan_buffer (4x4 and 8x8 instances).
module tb_zigzag_scan_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  logic              in_valid4, in_ready4, out_valid4, out_ready4, out_last4;
  logic signed [8:0] in_data4, out_data4;
  logic [3:0]        out_idx4;
  logic [4:0]        out_nz4;

  logic              in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
  logic signed [8:0] in_data8, out_data8;
  logic [5:0]        out_idx8;
  logic [6:0]        out_nz8;

  zigzag_scan_buffer #(.WIDTH(9), .BLK_DIM(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_idx(out_idx4), .out_last(out_last4), .out_nz_count(out_nz4)
  );

  zigzag_scan_buffer #(.WIDTH(9), .BLK_DIM(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_idx(out_idx8), .out_last(out_last8), .out_nz_count(out_nz8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int                zz4 [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int                zz8_head [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
  logic signed [8:0] blk [16];
  logic signed [8:0] rec_data [16];
  int                rec_idx [16];
  int                rec_last [16];
  int                rec_nz [16];
  int                t_last, first_cyc;

  task automatic load4();
    int to;
    for (int i = 0; i < 16; i++) begin
      in_valid4 = 1'b1;
      in_data4  = blk[i];
      to = 0;
      while (!in_ready4 && to < 200) begin
        @(posedge clk); #1;
        to++;
      end
      if (to >= 200) check("load_timeout", to, 0);
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    in_data4  = '0;
    t_last    = cyc;
  endtask

  task automatic collect4(input int n, input bit rnd);
    int         k, to;
    bit         hold;
    logic [19:0] snap;
    k = 0; to = 0; hold = 1'b0; snap = '0; first_cyc = -1;
    while (k < n && to < 3000) begin
`ifndef ZZ_PING_PONG_EN
      check("in_ready_scan", in_ready4, 0);
`endif
      if (out_valid4 && first_cyc < 0) first_cyc = cyc;
      out_ready4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hold = out_valid4 && !out_ready4;
      snap = {out_valid4, out_data4, out_idx4, out_last4, out_nz4};
      if (out_valid4 && out_ready4) begin
        rec_data[k] = out_data4;
        rec_idx[k]  = int'(out_idx4);
        rec_last[k] = int'(out_last4);
        rec_nz[k]   = int'(out_nz4);
        k++;
      end
      @(posedge clk); #1;
      to++;
      if (hold) check("stall_hold", {out_valid4, out_data4, out_idx4, out_last4, out_nz4}, snap);
    end
    out_ready4 = 1'b0;
    check("out_count", k, n);
  endtask

  initial begin
    int k, to, b, p, e;
    rst = 1'b0;
    in_valid4 = 0; in_data4 = '0; out_ready4 = 0;
    in_valid8 = 0; in_data8 = '0; out_ready8 = 0;

    #12;
    check("rst_in_ready", in_ready4, 0);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_data", out_data4, 0);
    check("rst_out_idx", out_idx4, 0);
    check("rst_out_last", out_last4, 0);
    check("rst_out_nz", out_nz4, 0);
    check("rst_in_ready8", in_ready8, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready4, 1);

    // raster 0..15, no stalls
    for (int i = 0; i < 16; i++) blk[i] = 9'(i);
    load4();
    collect4(16, 1'b0);
    check("latency", first_cyc, t_last + 2);
    for (int i = 0; i < 16; i++) begin
      check("t1_data", rec_data[i], zz4[i]);
      check("t1_idx", rec_idx[i], i);
      check("t1_last", rec_last[i], (i == 15) ? 1 : 0);
    end
    check("b2b_in_ready", in_ready4, 1);

    // three non-zero coefficients, including a negative one
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 9'sd3; blk[3] = -9'sd1; blk[15] = 9'sd7;
    load4();
    collect4(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("nz3_count", rec_nz[i], 3);
      check("nz3_data", rec_data[i], blk[zz4[i]]);
    end

    for (int i = 0; i < 16; i++) blk[i] = '0;
    load4();
    collect4(16, 1'b0);
    for (int i = 0; i < 16; i++) check("nz0_count", rec_nz[i], 0);

    // random backpressure
    for (int i = 0; i < 16; i++) blk[i] = 9'(10 * i - 50);
    load4();
    collect4(16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check("rnd_data", rec_data[i], blk[zz4[i]]);
      check("rnd_idx", rec_idx[i], i);
    end

    // reset in the middle of a scan
    for (int i = 0; i < 16; i++) blk[i] = 9'(i + 100);
    load4();
    collect4(8, 1'b0);
    check("pre_rst_idx", rec_idx[7], 7);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid4, 0);
    check("mid_rst_idx", out_idx4, 0);
    check("mid_rst_in_ready", in_ready4, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) blk[i] = 9'(5 * i - 30);
    load4();
    collect4(16, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("post_rst_data", rec_data[i], blk[zz4[i]]);
      check("post_rst_idx", rec_idx[i], i);
    end

    // 8x8 block
    for (int i = 0; i < 64; i++) begin
      in_valid8 = 1'b1;
      in_data8  = 9'(i);
      to = 0;
      while (!in_ready8 && to < 200) begin
        @(posedge clk); #1;
        to++;
      end
      if (to >= 200) check("load8_timeout", to, 0);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    k = 0; to = 0;
    while (k < 64 && to < 500) begin
      if (out_valid8) begin
        if (k < 10) check("t8_data", out_data8, zz8_head[k]);
        check("t8_idx", out_idx8, k);
        check("t8_last", out_last8, (k == 63) ? 1 : 0);
        k++;
      end
      @(posedge clk); #1;
      to++;
    end
    out_ready8 = 1'b0;
    check("t8_count", k, 64);

`ifdef ZZ_PING_PONG_EN
    // four back-to-back blocks streaming through both banks; block b has 4b+1 non-zeros
    fork
      begin
        for (int bb = 0; bb < 4; bb++) begin
          for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1;
            in_data4  = (i <= 4 * bb) ? 9'(i + 1) : 9'sd0;
            check("pp_in_ready", in_ready4, 1);
            @(posedge clk); #1;
          end
        end
        in_valid4 = 1'b0;
      end
      begin
        out_ready4 = 1'b1;
        k = 0; to = 0;
        while (k < 64 && to < 400) begin
          if (out_valid4) begin
            b = k / 16;
            p = k % 16;
            e = (zz4[p] <= 4 * b) ? zz4[p] + 1 : 0;
            check("pp_data", out_data4, e);
            check("pp_idx", out_idx4, p);
            check("pp_nz", out_nz4, 4 * b + 1);
            k++;
          end else if (k > 0) begin
            check("pp_gap", out_valid4, 1);
          end
          @(posedge clk); #1;
          to++;
        end
        out_ready4 = 1'b0;
        check("pp_count", k, 64);
      end
    join
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zigzag_scan_buffer.md
Name: zigzag_scan_buffer

Overview:
Parametrised block buffer that accepts residual coefficients in raster order and replays them in zigzag order for the CAVLC encoder. It replaces the fixed 4x4 counter + zigzag ROM + dual-port BRAM chain with one unit that adds:
- selectable 4x4/8x8 block size
- valid/ready handshakes on both sides
- a per-block non-zero coefficient count (feeds TotalCoeff).

It sits between the transform/quant stage and the CAVLC encoder.

Parameters:
WIDTH, 9, coefficient width in bits (two's complement)
BLK_DIM, 4, block edge length; legal values 4 or 8; elaboration error otherwise
NCOEF, BLK_DIM*BLK_DIM, derived: coefficients per block (not overridable)
AW, $clog2(NCOEF), derived: coefficient index width
CW, $clog2(NCOEF+1), derived: non-zero count width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
in_valid  in  1  input coefficient valid
in_ready  out  1  block can accept the coefficient this cycle
in_data  in  WIDTH  coefficient, raster order
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  coefficient, zigzag order
out_idx  out  AW  zigzag scan position 0..NCOEF-1
out_last  out  1  high with out_idx==NCOEF-1
out_nz_count  out  CW  non-zero count of the block being output; stable for the whole block

Behaviour:
- Reset (rst=0, async): state LOAD, all counters 0. out_valid, out_data, out_idx, out_last, out_nz_count = 0. in_ready=0 while rst=0, and 1 from the first clk edge after release.
- Input transfer: in_valid & in_ready on a rising edge.
  - Writes mem[wr_cnt] and increments wr_cnt.
  - nz_acc increments when in_data != 0.
- FSM LOAD: in_ready=1. On the transfer with wr_cnt==NCOEF-1:
  - wr_cnt wraps to 0
  - nz_acc is latched into out_nz_count
  - nz_acc clears
  - go to SCAN.
- FSM SCAN: in_ready=0 (see optional feature).
  - Memory is synchronous-read, 1-cycle latency. Read address = zz_table[rd_cnt].
  - A read is issued when the output register is empty or is being consumed this cycle (out_valid=0 or out_ready=1).
  - rd_cnt increments per issued read.
  - Return to LOAD after the output transfer with out_last=1.
- Latency: last input accepted at edge t, then out_valid=1 at edge t+2 with out_idx=0.
  - Sustained throughput is 1 coefficient/cycle while out_ready=1.
  - Back-to-back blocks (non-ping-pong): next block's first input is accepted the cycle after the out_last transfer.
- Backpressure: while out_valid=1 and out_ready=0, the values out_data, out_idx, out_last and out_nz_count hold stable. No read is issued and no data is lost.
- in_valid with in_ready=0: ignored, no write.
- out_ready with out_valid=0: ignored.
- rst asserted mid-block: the partial block is discarded, out_valid drops immediately, and the FSM restarts in LOAD. Memory contents are not cleared; they are don't-care.
- The zigzag table is the standard H.264 frame scan:
  - 4x4: 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15
  - 8x8: standard 64-entry frame zigzag, generated at elaboration.

Optional Feature:
ZZ_PING_PONG_EN.
- Defined: two memory banks.
  - Load fills one bank while the other is scanned; banks swap when a load completes and the scan bank is free.
  - in_ready=0 only when one bank is fully loaded and waiting while the other is still scanning.
  - out_nz_count is latched per bank.
  - Continuous streaming sustains 1 coefficient/cycle in both directions.
- Undefined: single bank; in_ready=0 for all of SCAN, exactly as above.

Decomposition:
- Package zigzag_pkg:
  - function zz_index(blk_dim, pos) returning the raster index
  - localparam constants for the 4x4 and 8x8 tables
  - state enum typedef {LOAD, SCAN}
- One sub-module, zigzag_addr_gen: holds the rd_cnt counter and the table lookup; outputs rd_addr, rd_idx and rd_last.
- Memory is inferred inline as a dual-port BRAM.

Test Plan:
- BLK_DIM=4, load raster values 0..15 with out_ready=1 -> out_data sequence 0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15; out_last only on the 16th; first out_valid 2 cycles after the last input.
- BLK_DIM=8, load values 0..63 -> first 10 outputs 0,1,8,16,9,2,3,10,17,24; out_last at out_idx=63.
- Load 4x4 with values {3,0,0,-1, 0..0, 7} (3 non-zero) -> out_nz_count=3 for all 16 outputs; an all-zero block -> out_nz_count=0.
- Random out_ready with 50% duty -> output sequence identical to the no-stall run; outputs stable on every stalled cycle; in_ready=0 during SCAN (feature off).
- Drive rst=0 after 8 outputs of a block -> out_valid=0 at once; after release, a fresh 16-coefficient block scans correctly from out_idx=0.
- ZZ_PING_PONG_EN defined, 4 back-to-back blocks with in_valid=1 and out_ready=1 -> in_ready stays 1 after the first block; 64 outputs in consecutive cycles; per-block out_nz_count correct.
